rr_arb_mux: RTL and testbench

- Parametrised successor to the fixed 16-bit, 2-input datapath mux.
- Selects one of CHANNELS input streams, each WIDTH bits wide, using round-robin arbitration, or a fixed select in forced mode.
- Each input and the output use a valid/ready handshake, with one registered output stage.
- Sits between multiple CPU producers (ALU result, memory read data, immediate path, etc.) and a shared consumer such as the register-file write port.

---
 rtl/cpu_mux_pkg.sv | 31 +++
 rtl/rr_grant.sv | 38 +++
 rtl/rr_arb_mux.sv | 127 ++++++++++++
 tb/tb_rr_arb_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU datapath arbitration mux: default sizes,
// index-width helper, channel index type and output-stage state encoding.
package cpu_mux_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;

    // Smallest index width that can address n channels, never below one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_SEL_W = clog2_min1(DEF_CHANNELS);

    typedef logic [DEF_SEL_W-1:0] ch_idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set bit of i_mask scanning upward
// from i_ptr and wrapping modulo CHANNELS.
module rr_grant
    import cpu_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic [SEL_W-1:0]    o_grant,
    output logic                o_found
);

    int w_idx;

    // Priority scan starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = {SEL_W{1'b0}};
        o_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end else begin
                w_idx = w_idx;
            end
            if (!o_found && i_mask[w_idx[SEL_W-1:0]]) begin
                o_found = 1'b1;
                o_grant = w_idx[SEL_W-1:0];
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin (or force-selected) N:1 valid/ready mux with one registered
// output stage; sustains one word per cycle.
module rr_arb_mux
    import cpu_mux_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_VALID,
    output logic [CHANNELS-1:0]       IN_READY,
    input  logic                      FORCE_EN,
    input  logic [SEL_W-1:0]          FORCE_SEL,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic [SEL_W-1:0]          OUT_SEL,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
);

    out_state_t          r_state;
    out_state_t          w_state_nxt;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_ld;
    logic [CHANNELS-1:0] w_mask;
    logic [SEL_W-1:0]    w_grant;
    logic                w_found;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_sel_data;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_grant (
        .i_mask  (w_mask),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    // Candidate mask, handshake and data select; out-of-range FORCE_SEL matches no channel.
    always_comb begin
        w_ld       = (r_state == ST_EMPTY) || OUT_READY;
        w_mask     = {CHANNELS{1'b0}};
        w_sel_data = {WIDTH{1'b0}};
        IN_READY   = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (FORCE_EN) begin
                w_mask[i] = IN_VALID[i] && (FORCE_SEL == SEL_W'(i));
            end else begin
                w_mask[i] = IN_VALID[i];
            end
            if (w_grant == SEL_W'(i)) begin
                w_sel_data  = IN_DATA[i*WIDTH +: WIDTH];
                IN_READY[i] = RST_N && w_ld && w_found;
            end else begin
                IN_READY[i] = 1'b0;
            end
        end
        w_xfer = RST_N && w_ld && w_found;
    end

    // Output-stage next state: load wins, otherwise drain on OUT_READY.
    always_comb begin
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else if (OUT_READY) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data, source index and pointer; forced grants leave the pointer alone.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_data <= {WIDTH{1'b0}};
            r_out_sel  <= {SEL_W{1'b0}};
            r_ptr      <= {SEL_W{1'b0}};
        end else if (w_xfer) begin
            r_out_data <= w_sel_data;
            r_out_sel  <= w_grant;
            if (FORCE_EN) begin
                r_ptr <= r_ptr;
            end else if (w_grant == SEL_W'(CHANNELS - 1)) begin
                r_ptr <= {SEL_W{1'b0}};
            end else begin
                r_ptr <= w_grant + SEL_W'(1);
            end
        end else begin
            r_out_data <= r_out_data;
            r_out_sel  <= r_out_sel;
            r_ptr      <= r_ptr;
        end
    end

    assign OUT_VALID = (r_state == ST_FULL);
    assign OUT_DATA  = r_out_data;
    assign OUT_SEL   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: directed scenarios then random traffic,
// checked against a queue-based round-robin reference model.
module tb_rr_arb_mux;
    import cpu_mux_pkg::*;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int SW = clog2_min1(CH);

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [CH*W-1:0] IN_DATA;
    logic [CH-1:0]   IN_VALID;
    logic [CH-1:0]   IN_READY;
    logic            FORCE_EN;
    ch_idx_t         FORCE_SEL;
    logic [W-1:0]    OUT_DATA;
    ch_idx_t         OUT_SEL;
    logic            OUT_VALID;
    logic            OUT_READY;

    rr_arb_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .FORCE_EN  (FORCE_EN),
        .FORCE_SEL (FORCE_SEL),
        .OUT_DATA  (OUT_DATA),
        .OUT_SEL   (OUT_SEL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] sel;
    } word_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    word_t        sb_q[$];
    int           m_ptr;
    bit           m_full;
    logic [W-1:0] chan_data [CH];
    logic [CH-1:0] last_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check handshake against the model, advance the model.
    task automatic step(input logic [CH-1:0] v, input bit fen, input int fsel,
                        input bit ordy, input bit refresh);
        logic [CH-1:0] cand;
        logic [CH-1:0] exp_rdy;
        bit            ld;
        bit            found;
        int            g;
        int            idx;
        @(posedge CLK);
        #1;
        IN_VALID  = v;
        FORCE_EN  = fen;
        FORCE_SEL = SW'(fsel);
        OUT_READY = ordy;
        for (int i = 0; i < CH; i++) IN_DATA[i*W +: W] = chan_data[i];
        #1;
        check("out_valid", {63'd0, OUT_VALID}, {63'd0, m_full});
        ld    = !m_full || ordy;
        cand  = fen ? (v & (CH'(1) << fsel)) : v;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < CH; k++) begin
            idx = (m_ptr + k) % CH;
            if (!found && ((cand >> idx) & CH'(1)) != '0) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy    = (ld && found) ? (CH'(1) << g) : '0;
        last_ready = IN_READY;
        check("in_ready", {60'd0, IN_READY}, {60'd0, exp_rdy});
        if (ld && found) begin
            sb_q.push_back(word_t'{data: chan_data[g], sel: SW'(g)});
            m_full = 1'b1;
            if (!fen) m_ptr = (g + 1) % CH;
            if (refresh) chan_data[g] = W'($urandom);
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: every word the consumer accepts must be the oldest expected one.
    always @(negedge CLK) begin
        word_t e;
        if (RST_N === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got word %0h sel %0d, expected none", OUT_DATA, OUT_SEL);
            end else begin
                e = sb_q.pop_front();
                check("out_data", {48'd0, OUT_DATA}, {48'd0, e.data});
                check("out_sel", {62'd0, OUT_SEL}, {62'd0, e.sel});
            end
        end
    end

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = '1;
        IN_DATA   = '0;
        FORCE_EN  = 1'b0;
        FORCE_SEL = '0;
        OUT_READY = 1'b1;
        m_ptr     = 0;
        m_full    = 1'b0;
        for (int i = 0; i < CH; i++) chan_data[i] = '0;
        #2;
        check("rst_in_ready", {60'd0, IN_READY}, 64'd0);
        check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        IN_VALID = '0;
        #20 RST_N = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b0, 0, 1'b1, 1'b0);
        check("idle_out_data", {48'd0, OUT_DATA}, 64'd0);
        check("idle_out_sel", {62'd0, OUT_SEL}, 64'd0);

        // Full-rate rotation over all channels.
        for (int i = 0; i < CH; i++) chan_data[i] = W'(16'hA000 + i);
        for (int c = 0; c < 8; c++) step(4'b1111, 1'b0, 0, 1'b1, 1'b0);

        // Backpressure holds the word; next grant follows the pointer.
        chan_data[2] = 16'h1234;
        step(4'b0100, 1'b0, 0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 0, 1'b0, 1'b0);
            check("bp_data", {48'd0, OUT_DATA}, 64'h1234);
            check("bp_sel", {62'd0, OUT_SEL}, 64'd2);
            check("bp_ready", {60'd0, last_ready}, 64'd0);
        end
        step(4'b1111, 1'b0, 0, 1'b1, 1'b0);
        check("bp_next_grant", {60'd0, last_ready}, 64'b1000);

        // Forced select keeps the pointer at 3.
        step(4'b0100, 1'b0, 0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(4'b1111, 1'b1, 1, 1'b1, 1'b0);
            check("force_grant", {60'd0, last_ready}, 64'b0010);
        end
        step(4'b1111, 1'b0, 0, 1'b1, 1'b0);
        check("force_resume", {60'd0, last_ready}, 64'b1000);

        // Pointer wrap after a grant to the last channel.
        step(4'b1000, 1'b0, 0, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 0, 1'b1, 1'b0);
        check("wrap_grant", {60'd0, last_ready}, 64'b0001);

        // Asynchronous reset while a word is held.
        chan_data[1] = 16'h00FF;
        step(4'b0010, 1'b0, 0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 0, 1'b0, 1'b0);
        check("full_data", {48'd0, OUT_DATA}, 64'h00FF);
        @(posedge CLK);
        #3;
        RST_N    = 1'b0;
        IN_VALID = '1;
        #1;
        check("arst_valid", {63'd0, OUT_VALID}, 64'd0);
        check("arst_data", {48'd0, OUT_DATA}, 64'd0);
        check("arst_ready", {60'd0, IN_READY}, 64'd0);
        sb_q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        IN_VALID = '0;
        @(posedge CLK);
        #4 RST_N = 1'b1;
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, 0, 1'b1, 1'b0);

        // Random traffic with occasional forced selects and backpressure.
        for (int i = 0; i < CH; i++) chan_data[i] = W'($urandom);
        for (int c = 0; c < 400; c++) begin
            step(CH'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, CH - 1),
                 ($urandom_range(0, 3) != 0), 1'b1);
        end

        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, 0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
